// File: rtl/tl_sensor_cond_pkg.sv
// Shared definitions for the traffic-light sensor conditioning stage.
// Provides the default build parameters and the per-channel presence FSM
// state encoding used by tl_sensor_chan.
package tl_sensor_cond_pkg;

  // Default build parameters
  localparam int unsigned DB_CYCLES_DEF   = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 8;
  localparam int unsigned CNT_W_DEF       = 8;

  // Presence FSM encoding; 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    HOLD    = 2'b10
  } state_e;

endpackage : tl_sensor_cond_pkg

// File: rtl/tl_sensor_chan.sv
// One detector channel: 2-flop synchroniser, debounce, presence FSM with
// hold-off extension, and a saturating arrival counter.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   raw            - raw asynchronous detector input
//   cnt_clr        - synchronous clear of the arrival counter
//   t              - conditioned traffic-present flag (registered)
//   car_cnt        - saturating count of entries into PRESENT (registered)
module tl_sensor_chan
  import tl_sensor_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             cnt_clr,
  output logic             t,
  output logic [CNT_W-1:0] car_cnt
);

  localparam int unsigned DCNT_W = $clog2(DB_CYCLES) + 1;
  localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DCNT_W-1:0] DB_LAST   = DCNT_W'(DB_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              db_q, db_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  state_e            state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              t_q, t_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enter_present_c;

  // Next-state logic for the whole channel
  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    db_d    = db_q;
    dcnt_d  = dcnt_q;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;

    // Debounce: a new level must persist DB_CYCLES cycles; any return restarts
    if (s2_q == db_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DB_LAST) begin
      db_d   = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end

    // Presence FSM; re-arrival during HOLD wins over hold expiry
    case (state_q)
      IDLE: begin
        if (db_q) state_d = PRESENT;
      end
      PRESENT: begin
        if (!db_q) begin
          state_d = HOLD;
          hcnt_d  = HOLD_LAST;
        end
      end
      HOLD: begin
        if (db_q) begin
          state_d = PRESENT;
        end else if (hcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q - HCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    enter_present_c = (state_d == PRESENT) && (state_q != PRESENT);

    // Arrival counter: clear beats increment, saturate at all-ones
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (enter_present_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    t_d = (state_d != IDLE);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      dcnt_q  <= '0;
      state_q <= IDLE;
      hcnt_q  <= '0;
      t_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
    end
  end

  assign t       = t_q;
  assign car_cnt = cnt_q;

endmodule : tl_sensor_chan

// File: rtl/tl_sensor_cond.sv
// Sensor conditioning stage for the traffic light controller: two
// independent, identical channels producing clean Ta/Tb flags and
// saturating per-street arrival counts.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   raw_a, raw_b          - raw asynchronous detector inputs
//   cnt_clr               - synchronous clear of both arrival counters
//   Ta, Tb                - conditioned traffic-present flags
//   car_cnt_a, car_cnt_b  - saturating arrival counts
module tl_sensor_cond
  import tl_sensor_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic             cnt_clr,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] car_cnt_a,
  output logic [CNT_W-1:0] car_cnt_b
);

  tl_sensor_chan #(
    .DB_CYCLES   (DB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .raw     (raw_a),
    .cnt_clr (cnt_clr),
    .t       (Ta),
    .car_cnt (car_cnt_a)
  );

  tl_sensor_chan #(
    .DB_CYCLES   (DB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .raw     (raw_b),
    .cnt_clr (cnt_clr),
    .t       (Tb),
    .car_cnt (car_cnt_b)
  );

endmodule : tl_sensor_cond

// File: tb/tb_tl_sensor_cond.sv
// Directed scoreboard bench for tl_sensor_cond with default parameters
// (DB_CYCLES=4, HOLD_CYCLES=8, CNT_W=8). Edge k is the k-th rising edge
// after an input change; outputs are sampled 1 time unit after each edge.
module tb_tl_sensor_cond;

  localparam int unsigned CW = 8;

  typedef struct {
    string          tag;
    logic           ta;
    logic           tb;
    logic [CW-1:0]  ca;
    logic [CW-1:0]  cb;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          raw_a = 1'b0;
  logic          raw_b = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          Ta, Tb;
  logic [CW-1:0] car_cnt_a, car_cnt_b;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  tl_sensor_cond #(
    .DB_CYCLES   (4),
    .HOLD_CYCLES (8),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_a     (raw_a),
    .raw_b     (raw_b),
    .cnt_clr   (cnt_clr),
    .Ta        (Ta),
    .Tb        (Tb),
    .car_cnt_a (car_cnt_a),
    .car_cnt_b (car_cnt_b)
  );

  always #5 clk = ~clk;

  // Advance one edge without checking
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expectation for the coming edge, advance, then pop and compare
  task automatic step(input string tag, input logic ta, input logic tb,
                      input logic [CW-1:0] ca, input logic [CW-1:0] cb);
    exp_t e;
    e.tag = tag; e.ta = ta; e.tb = tb; e.ca = ca; e.cb = cb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_checks++;
    assert ({Ta, Tb, car_cnt_a, car_cnt_b} === {e.ta, e.tb, e.ca, e.cb})
    else begin
      n_errors++;
      $error("FAIL %s: observed Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d, expected Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d",
             e.tag, Ta, Tb, car_cnt_a, car_cnt_b, e.ta, e.tb, e.ca, e.cb);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw_a = 1'b0;
    raw_b = 1'b0;
    cnt_clr = 1'b0;
    step("reset", 1'b0, 1'b0, CW'(0), CW'(0));
    reset = 1'b0;
  endtask

  initial begin
    // 1. Reset with raws high, then release
    reset = 1'b1; raw_a = 1'b1; raw_b = 1'b1;
    step("rst_hold0", 1'b0, 1'b0, CW'(0), CW'(0));
    step("rst_hold1", 1'b0, 1'b0, CW'(0), CW'(0));
    reset = 1'b0;
    for (int k = 0; k <= 6; k++)
      step("rst_release", k >= 6, k >= 6, CW'(k >= 6 ? 1 : 0), CW'(k >= 6 ? 1 : 0));
    raw_a = 1'b0; raw_b = 1'b0;
    for (int k = 0; k <= 17; k++)
      step("rst_fall", k <= 13, k <= 13, CW'(1), CW'(1));

    // 2. Glitch rejection: 3-cycle pulse, then fast toggling
    do_reset();
    for (int k = 0; k <= 14; k++) begin
      raw_a = (k <= 2);
      step("glitch3", 1'b0, 1'b0, CW'(0), CW'(0));
    end
    for (int i = 0; i < 50; i++) begin
      raw_a = i[0];
      step("toggle", 1'b0, 1'b0, CW'(0), CW'(0));
    end
    raw_a = 1'b0;

    // 3. Clean pulse: high E0..E9
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      raw_a = (k <= 9);
      step("clean", (k >= 6) && (k <= 23), 1'b0, CW'(k >= 6 ? 1 : 0), CW'(0));
    end

    // 4. Re-arrival on the last HOLD cycle keeps Ta high, counts again
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      raw_a = (k <= 9) || (k >= 18);
      step("rearrive", k >= 6, 1'b0,
           CW'(k >= 24 ? 2 : (k >= 6 ? 1 : 0)), CW'(0));
    end

    // 5. Saturation of car_cnt_b, then clear coinciding with an entry
    do_reset();
    for (int p = 1; p <= 260; p++) begin
      for (int j = 0; j < 11; j++) begin
        raw_b = (j < 6);
        tick();
      end
      raw_b = 1'b0;
      if (p == 1 || p == 10 || p == 254 || p == 255 || p == 256 || p == 260)
        step("sat", 1'b0, 1'b1, CW'(0), CW'(p > 255 ? 255 : p));
      else
        tick();
    end
    raw_b = 1'b0;
    for (int k = 0; k < 29; k++) tick();
    step("sat_idle", 1'b0, 1'b0, CW'(0), CW'(255));
    raw_b = 1'b1;
    for (int k = 0; k <= 5; k++)
      step("clr_pre", 1'b0, 1'b0, CW'(0), CW'(255));
    cnt_clr = 1'b1;
    step("clr_entry", 1'b0, 1'b1, CW'(0), CW'(0));
    cnt_clr = 1'b0;
    step("clr_after", 1'b0, 1'b1, CW'(0), CW'(0));
    step("clr_after2", 1'b0, 1'b1, CW'(0), CW'(0));

    // 6. Identical channels, then reset in the middle of HOLD
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      raw_a = (k <= 9);
      raw_b = (k <= 9);
      step("twin", k >= 6, k >= 6, CW'(k >= 6 ? 1 : 0), CW'(k >= 6 ? 1 : 0));
    end
    reset = 1'b1;
    step("hold_rst", 1'b0, 1'b0, CW'(0), CW'(0));
    reset = 1'b0;
    for (int k = 0; k < 5; k++)
      step("post_rst", 1'b0, 1'b0, CW'(0), CW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tl_sensor_cond
